// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencing controller: accepts padded blocks, issues the
// load / 64-round / feed-forward control pulses to core, K ROM and scheduler,
// and holds the digest-valid handshake after the last block of a message.
// Optional build macro: SHA256_ROUND_CTRL_ABORT_EN adds abort_i.
module sha256_round_ctrl #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blk_valid_i,
  input  logic             blk_first_i,
  input  logic             blk_last_i,
  output logic             blk_ready_o,
  output logic             sched_load_o,
  output logic             core_init_o,
  output logic             core_start_o,
  output logic             round_en_o,
  output logic [5:0]       round_o,
  output logic             feed_o,
  output logic             digest_valid_o,
  input  logic             digest_ready_i,
`ifdef SHA256_ROUND_CTRL_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             busy_o,
  output logic [CNT_W-1:0] blk_cnt_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FEED,
    OUT
  } state_t;

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  state_t           state;
  state_t           state_nxt;
  logic             first_q;
  logic             last_q;
  logic             expect_first;
  logic [5:0]       round;
  logic [CNT_W-1:0] blk_cnt;
  logic             err;
  logic             accept;
  logic             abort;

  assign accept = (state == IDLE) && blk_valid_i;

`ifdef SHA256_ROUND_CTRL_ABORT_EN
  assign abort = abort_i && (state inside {LOAD, ROUND, FEED});
`else
  assign abort = 1'b0;
`endif

  assign round_o   = round;
  assign blk_cnt_o = blk_cnt;
  assign err_o     = err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and per-state control outputs.
  always_comb begin
    state_nxt      = state;
    blk_ready_o    = 1'b0;
    sched_load_o   = 1'b0;
    core_init_o    = 1'b0;
    core_start_o   = 1'b0;
    round_en_o     = 1'b0;
    feed_o         = 1'b0;
    digest_valid_o = 1'b0;
    busy_o         = (state != IDLE);
    case (state)
      IDLE: begin
        blk_ready_o = 1'b1;
        if (blk_valid_i) state_nxt = LOAD;
      end
      LOAD: begin
        sched_load_o = 1'b1;
        core_start_o = 1'b1;
        core_init_o  = first_q;
        state_nxt    = ROUND;
      end
      ROUND: begin
        round_en_o = 1'b1;
        if (round == LAST_ROUND) state_nxt = FEED;
      end
      FEED: begin
        feed_o    = 1'b1;
        state_nxt = last_q ? OUT : IDLE;
      end
      OUT: begin
        digest_valid_o = 1'b1;
        if (digest_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Round index: steps through ROUND and is back at 0 on exit or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                round <= '0;
    else if (abort)            round <= '0;
    else if (state == ROUND)   round <= (round == LAST_ROUND) ? 6'd0 : round + 6'd1;
  end

  // Block framing: latched flags, expect-first tracking and sticky error.
  // A missing first while expecting one is promoted to first, so first_q is
  // the effective flag that drives core_init_o and the counter restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      expect_first <= 1'b1;
      err          <= 1'b0;
    end else begin
      if (accept) begin
        first_q      <= expect_first | blk_first_i;
        last_q       <= blk_last_i;
        expect_first <= 1'b0;
        if (expect_first != blk_first_i) err <= 1'b1;
      end
      if (abort || ((state == OUT) && digest_ready_i)) expect_first <= 1'b1;
    end
  end

  // Per-message block counter, updated as the block leaves LOAD; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if ((state == LOAD) && !abort) begin
      if (first_q)             blk_cnt <= CNT_W'(1);
      else if (blk_cnt != '1)  blk_cnt <= blk_cnt + CNT_W'(1);
    end
  end

endmodule
